// File: rtl/arm_pipeline_controller.sv
// arm_pipeline_controller: decode, Execute/Memory/Writeback control registers, NZCV flags
// and condition gating for the 5-stage ARM core. Define ARM_BL_EN to enable BL (link write).
module arm_pipeline_controller (
  input  logic        clk,
  input  logic        reset,
  input  logic [19:0] InstrD,
  input  logic [3:0]  ALUFlagsE,
  input  logic        FlushE,
  output logic [1:0]  RegSrcD,
  output logic [1:0]  ImmSrcD,
  output logic        ALUSrcE,
  output logic [2:0]  ALUControlE,
  output logic        BranchTakenE,
  output logic        MemtoRegE,
  output logic        RegWriteM,
  output logic        MemWriteM,
  output logic        RegWriteW,
  output logic        MemtoRegW,
  output logic        PCSrcW,
  output logic        BrLW,
  output logic        PCWrPendingF
);
  typedef struct packed {
    logic       pcs;
    logic       reg_w;
    logic       mem_w;
    logic       branch;
`ifdef ARM_BL_EN
    logic       br_l;
`endif
    logic       mem_to_reg;
    logic       alu_src;
    logic [2:0] alu_control;
    logic [1:0] flag_w;
    logic [3:0] cond;
  } ex_ctrl_t;

  typedef struct packed {
    logic reg_write;
    logic mem_write;
    logic pcs;
`ifdef ARM_BL_EN
    logic br_l;
`endif
    logic mem_to_reg;
  } mem_ctrl_t;

  typedef struct packed {
    logic reg_write;
    logic pcs;
`ifdef ARM_BL_EN
    logic br_l;
`endif
    logic mem_to_reg;
  } wb_ctrl_t;

  logic [1:0] op_d;
  logic [5:0] funct_d;
  logic [3:0] rd_d;
  logic       unused_rn;
  logic       alu_op_d;
  ex_ctrl_t   ctrl_d, ex_d, ex_q;
  mem_ctrl_t  m_d, m_q;
  wb_ctrl_t   w_d, w_q;
  logic [3:0] flags_d, flags_q;
  logic       n_f, z_f, c_f, v_f;
  logic       cond_ex;

  assign op_d      = InstrD[15:14];
  assign funct_d   = InstrD[13:8];
  assign rd_d      = InstrD[3:0];
  assign unused_rn = ^InstrD[7:4];

  always_comb begin : decoder
    ctrl_d      = '0;
    RegSrcD     = 2'b00;
    ImmSrcD     = 2'b00;
    alu_op_d    = 1'b0;
    ctrl_d.cond = InstrD[19:16];
    case (op_d)
      2'b00: begin
        ctrl_d.alu_src = funct_d[5];
        ctrl_d.reg_w   = 1'b1;
        alu_op_d       = 1'b1;
      end
      2'b01: begin
        ImmSrcD        = 2'b01;
        ctrl_d.alu_src = 1'b1;
        if (funct_d[0]) begin
          ctrl_d.reg_w      = 1'b1;
          ctrl_d.mem_to_reg = 1'b1;
        end else begin
          ctrl_d.mem_w = 1'b1;
          RegSrcD      = 2'b10;
        end
      end
      2'b10: begin
        RegSrcD        = 2'b01;
        ImmSrcD        = 2'b10;
        ctrl_d.alu_src = 1'b1;
        ctrl_d.branch  = 1'b1;
`ifdef ARM_BL_EN
        ctrl_d.br_l    = funct_d[4];
`endif
      end
      default: ;
    endcase
    // Only ADD/SUB may write C and V; logical ops and shifts update N and Z only.
    if (alu_op_d) begin
      case (funct_d[4:1])
        4'b0100: begin ctrl_d.alu_control = 3'b000; ctrl_d.flag_w = {2{funct_d[0]}}; end
        4'b0010: begin ctrl_d.alu_control = 3'b001; ctrl_d.flag_w = {2{funct_d[0]}}; end
        4'b0000: begin ctrl_d.alu_control = 3'b010; ctrl_d.flag_w = {funct_d[0], 1'b0}; end
        4'b1100: begin ctrl_d.alu_control = 3'b011; ctrl_d.flag_w = {funct_d[0], 1'b0}; end
        4'b1101: begin ctrl_d.alu_control = 3'b100; ctrl_d.flag_w = {funct_d[0], 1'b0}; end
        default: begin ctrl_d.alu_control = 3'b000; ctrl_d.flag_w = 2'b00; end
      endcase
    end
    ctrl_d.pcs = (ctrl_d.reg_w & (rd_d == 4'hf)) | ctrl_d.branch;
  end

  always_comb begin
    ex_d = ctrl_d;
    if (FlushE) ex_d = '0;
  end

  assign {n_f, z_f, c_f, v_f} = flags_q;

  always_comb begin
    cond_ex = 1'b0;
    case (ex_q.cond)
      4'b0000: cond_ex = z_f;
      4'b0001: cond_ex = ~z_f;
      4'b0010: cond_ex = c_f;
      4'b0011: cond_ex = ~c_f;
      4'b0100: cond_ex = n_f;
      4'b0101: cond_ex = ~n_f;
      4'b0110: cond_ex = v_f;
      4'b0111: cond_ex = ~v_f;
      4'b1000: cond_ex = c_f & ~z_f;
      4'b1001: cond_ex = ~c_f | z_f;
      4'b1010: cond_ex = (n_f == v_f);
      4'b1011: cond_ex = (n_f != v_f);
      4'b1100: cond_ex = ~z_f & (n_f == v_f);
      4'b1101: cond_ex = z_f | (n_f != v_f);
      4'b1110: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

  always_comb begin
    flags_d = flags_q;
    if (ex_q.flag_w[1] & cond_ex) flags_d[3:2] = ALUFlagsE[3:2];
    if (ex_q.flag_w[0] & cond_ex) flags_d[1:0] = ALUFlagsE[1:0];
  end

  always_comb begin
    m_d.reg_write  = ex_q.reg_w & cond_ex;
    m_d.mem_write  = ex_q.mem_w & cond_ex;
    m_d.pcs        = ex_q.pcs & cond_ex;
`ifdef ARM_BL_EN
    m_d.br_l       = ex_q.br_l & cond_ex;
`endif
    m_d.mem_to_reg = ex_q.mem_to_reg;
    w_d.reg_write  = m_q.reg_write;
    w_d.pcs        = m_q.pcs;
`ifdef ARM_BL_EN
    w_d.br_l       = m_q.br_l;
`endif
    w_d.mem_to_reg = m_q.mem_to_reg;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_q    <= '0;
      m_q     <= '0;
      w_q     <= '0;
      flags_q <= 4'b0000;
    end else begin
      ex_q    <= ex_d;
      m_q     <= m_d;
      w_q     <= w_d;
      flags_q <= flags_d;
    end
  end

  assign ALUSrcE      = ex_q.alu_src;
  assign ALUControlE  = ex_q.alu_control;
  assign MemtoRegE    = ex_q.mem_to_reg;
  assign BranchTakenE = ex_q.branch & cond_ex;
  assign RegWriteM    = m_q.reg_write;
  assign MemWriteM    = m_q.mem_write;
  assign RegWriteW    = w_q.reg_write;
  assign MemtoRegW    = w_q.mem_to_reg;
  assign PCSrcW       = w_q.pcs;
`ifdef ARM_BL_EN
  assign BrLW         = w_q.br_l;
`else
  assign BrLW         = 1'b0;
`endif
  // Execute term is post-gating so a failed conditional branch releases fetch right away.
  assign PCWrPendingF = ctrl_d.pcs | m_d.pcs | m_q.pcs;
endmodule

// File: tb/tb_arm_pipeline_controller.sv
// Self-checking bench for arm_pipeline_controller: instruction-level reference model,
// directed scenarios with literal expectations, then randomized traffic.
module tb_arm_pipeline_controller;
  logic        clk = 1'b0;
  logic        reset;
  logic [19:0] InstrD;
  logic [3:0]  ALUFlagsE;
  logic        FlushE;
  logic [1:0]  RegSrcD, ImmSrcD;
  logic        ALUSrcE;
  logic [2:0]  ALUControlE;
  logic        BranchTakenE, MemtoRegE, RegWriteM, MemWriteM;
  logic        RegWriteW, MemtoRegW, PCSrcW, BrLW, PCWrPendingF;

  always #5 clk = ~clk;

  arm_pipeline_controller dut (
    .clk(clk), .reset(reset), .InstrD(InstrD), .ALUFlagsE(ALUFlagsE), .FlushE(FlushE),
    .RegSrcD(RegSrcD), .ImmSrcD(ImmSrcD), .ALUSrcE(ALUSrcE), .ALUControlE(ALUControlE),
    .BranchTakenE(BranchTakenE), .MemtoRegE(MemtoRegE), .RegWriteM(RegWriteM),
    .MemWriteM(MemWriteM), .RegWriteW(RegWriteW), .MemtoRegW(MemtoRegW),
    .PCSrcW(PCSrcW), .BrLW(BrLW), .PCWrPendingF(PCWrPendingF)
  );

  localparam int C_NOP = 0, C_DP = 1, C_LDR = 2, C_STR = 3, C_B = 4, C_BL = 5;
  localparam int K_ZERO = 0, K_BUB = 1, K_INS = 2;

  typedef struct {
    int          kind;
    logic [19:0] ins;
    bit          pass;
  } slot_t;

  slot_t      se, sm, sw;
  logic [3:0] flags;
  int         tests = 0;
  int         fails = 0;

  function automatic logic [19:0] mk(logic [3:0] c, logic [1:0] op, logic [5:0] f, logic [3:0] rd);
    return {c, op, f, 4'h0, rd};
  endfunction

  function automatic int cls(logic [19:0] ins);
    case (ins[15:14])
      2'b00: return C_DP;
      2'b01: return ins[8] ? C_LDR : C_STR;
`ifdef ARM_BL_EN
      2'b10: return ins[12] ? C_BL : C_B;
`else
      2'b10: return C_B;
`endif
      default: return C_NOP;
    endcase
  endfunction

  function automatic bit cond_ok(logic [3:0] c, logic [3:0] fl);
    bit n, z, cy, v;
    {n, z, cy, v} = fl;
    case (c)
      4'd0:  return z;            4'd1:  return !z;
      4'd2:  return cy;           4'd3:  return !cy;
      4'd4:  return n;            4'd5:  return !n;
      4'd6:  return v;            4'd7:  return !v;
      4'd8:  return cy && !z;     4'd9:  return !cy || z;
      4'd10: return n == v;       4'd11: return n != v;
      4'd12: return !z && n == v; 4'd13: return z || n != v;
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic int alu_of(logic [19:0] ins);
    if (cls(ins) != C_DP) return 0;
    case (ins[12:9])
      4'b0100: return 0;
      4'b0010: return 1;
      4'b0000: return 2;
      4'b1100: return 3;
      4'b1101: return 4;
      default: return 0;
    endcase
  endfunction

  function automatic bit alu_src_of(logic [19:0] ins);
    int c = cls(ins);
    if (c == C_DP) return ins[13];
    return c != C_NOP;
  endfunction

  function automatic bit is_branch(logic [19:0] ins);
    return cls(ins) == C_B || cls(ins) == C_BL;
  endfunction

  function automatic bit writes_reg(logic [19:0] ins);
    return cls(ins) == C_DP || cls(ins) == C_LDR;
  endfunction

  function automatic bit writes_pc(logic [19:0] ins);
    return (writes_reg(ins) && ins[3:0] == 4'hf) || is_branch(ins);
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    se = '{K_ZERO, 20'h0, 1'b0};
    sm = '{K_ZERO, 20'h0, 1'b0};
    sw = '{K_ZERO, 20'h0, 1'b0};
    flags = 4'b0000;
  endtask

  task automatic compare_all();
    int c;
    bit pe;
    c  = cls(InstrD);
    pe = (se.kind == K_INS) && cond_ok(se.ins[19:16], flags);
    check("RegSrcD", RegSrcD, (c == C_STR) ? 2 : (c == C_B || c == C_BL) ? 1 : 0);
    check("ImmSrcD", ImmSrcD, (c == C_LDR || c == C_STR) ? 1 : (c == C_B || c == C_BL) ? 2 : 0);
    if (se.kind != K_BUB) begin
      check("ALUSrcE", ALUSrcE, se.kind == K_INS && alu_src_of(se.ins));
      check("ALUControlE", ALUControlE, se.kind == K_INS ? alu_of(se.ins) : 0);
      check("MemtoRegE", MemtoRegE, se.kind == K_INS && cls(se.ins) == C_LDR);
    end
    check("BranchTakenE", BranchTakenE, pe && is_branch(se.ins));
    check("RegWriteM", RegWriteM, sm.pass && writes_reg(sm.ins));
    check("MemWriteM", MemWriteM, sm.pass && cls(sm.ins) == C_STR);
    check("RegWriteW", RegWriteW, sw.pass && writes_reg(sw.ins));
    check("PCSrcW", PCSrcW, sw.pass && writes_pc(sw.ins));
    if (sw.kind != K_BUB)
      check("MemtoRegW", MemtoRegW, sw.kind == K_INS && cls(sw.ins) == C_LDR);
`ifdef ARM_BL_EN
    check("BrLW", BrLW, sw.pass && cls(sw.ins) == C_BL);
`else
    check("BrLW", BrLW, 0);
`endif
    check("PCWrPendingF", PCWrPendingF,
          writes_pc(InstrD) || (pe && writes_pc(se.ins)) || (sm.pass && writes_pc(sm.ins)));
  endtask

  task automatic model_step();
    slot_t nm;
    if (reset) begin
      model_clear();
      return;
    end
    nm = '{se.kind, se.ins, 1'b0};
    if (se.kind == K_INS) nm.pass = cond_ok(se.ins[19:16], flags);
    if (nm.pass && cls(se.ins) == C_DP && se.ins[8]) begin
      flags[3:2] = ALUFlagsE[3:2];
      if (se.ins[12:9] == 4'b0100 || se.ins[12:9] == 4'b0010) flags[1:0] = ALUFlagsE[1:0];
    end
    sw = sm;
    sm = nm;
    se = FlushE ? '{K_BUB, 20'h0, 1'b0} : '{K_INS, InstrD, 1'b0};
  endtask

  task automatic cyc(logic [19:0] ins, logic [3:0] af, bit fl, bit rs);
    @(negedge clk);
    InstrD = ins; ALUFlagsE = af; FlushE = fl; reset = rs;
    if (rs) model_clear();
    #1;
    compare_all();
    model_step();
  endtask

  function automatic logic [19:0] rand_instr();
    logic [3:0] cmds [5];
    logic [3:0] c, rd;
    logic [1:0] op;
    logic [5:0] f;
    cmds = '{4'b0100, 4'b0010, 4'b0000, 4'b1100, 4'b1101};
    c  = ($urandom_range(0, 1) == 0) ? 4'he : 4'($urandom_range(0, 15));
    op = 2'($urandom_range(0, 3));
    if (op == 2'b00) f = {1'($urandom_range(0, 1)), cmds[$urandom_range(0, 4)], 1'($urandom_range(0, 1))};
    else             f = 6'($urandom_range(0, 63));
    rd = ($urandom_range(0, 3) == 0) ? 4'hf : 4'($urandom_range(0, 15));
    return {c, op, f, 4'($urandom_range(0, 15)), rd};
  endfunction

  logic [19:0] NOP, ADDS, BEQ, STRNE, LDRPC, ADDR, STR, BL;

  initial begin
    NOP   = mk(4'he, 2'b11, 6'b000000, 4'h0);
    ADDS  = mk(4'he, 2'b00, 6'b101001, 4'h1);
    BEQ   = mk(4'h0, 2'b10, 6'b000000, 4'h0);
    STRNE = mk(4'h1, 2'b01, 6'b000000, 4'h2);
    LDRPC = mk(4'he, 2'b01, 6'b011001, 4'hf);
    ADDR  = mk(4'he, 2'b00, 6'b001000, 4'h3);
    STR   = mk(4'he, 2'b01, 6'b000000, 4'h4);
    BL    = mk(4'he, 2'b10, 6'b010000, 4'h0);
    reset = 1'b1; InstrD = NOP; ALUFlagsE = 4'h0; FlushE = 1'b0;
    model_clear();

    cyc(NOP, 4'h0, 0, 1);
    check("rst_RegWriteW", RegWriteW, 0);
    // ADDS then BEQ taken on Z=1
    cyc(ADDS, 4'h0, 0, 0);
    check("adds_RegSrcD", RegSrcD, 0);
    cyc(NOP, 4'b0100, 0, 0);
    check("adds_ALUControlE", ALUControlE, 3'b000);
    check("adds_ALUSrcE", ALUSrcE, 1);
    cyc(BEQ, 4'h0, 0, 0);
    check("adds_RegWriteM", RegWriteM, 1);
    check("beq_PCWrPendingD", PCWrPendingF, 1);
    cyc(NOP, 4'h0, 0, 0);
    check("beq_taken", BranchTakenE, 1);
    check("adds_RegWriteW", RegWriteW, 1);
    // Z=0: BEQ not taken
    cyc(ADDS, 4'h0, 0, 0);
    cyc(NOP, 4'b0000, 0, 0);
    cyc(BEQ, 4'h0, 0, 0);
    check("beq2_PCWrPendingD", PCWrPendingF, 1);
    cyc(NOP, 4'h0, 0, 0);
    check("beq_not_taken", BranchTakenE, 0);
    check("beq_PCWr_dropped", PCWrPendingF, 0);
    // STRNE with Z=1 suppressed
    cyc(ADDS, 4'h0, 0, 0);
    cyc(NOP, 4'b0100, 0, 0);
    cyc(STRNE, 4'h0, 0, 0);
    cyc(NOP, 4'h0, 0, 0);
    cyc(NOP, 4'h0, 0, 0);
    check("strne_z1_MemWriteM", MemWriteM, 0);
    // STRNE with Z=0 writes exactly 2 cycles after Decode
    cyc(ADDS, 4'h0, 0, 0);
    cyc(NOP, 4'b0000, 0, 0);
    cyc(STRNE, 4'h0, 0, 0);
    cyc(NOP, 4'h0, 0, 0);
    check("strne_early_MemWriteM", MemWriteM, 0);
    cyc(NOP, 4'h0, 0, 0);
    check("strne_z0_MemWriteM", MemWriteM, 1);
    // LDR to PC
    cyc(LDRPC, 4'h0, 0, 0);
    check("ldrpc_pend_D", PCWrPendingF, 1);
    cyc(NOP, 4'h0, 0, 0);
    check("ldrpc_pend_E", PCWrPendingF, 1);
    cyc(NOP, 4'h0, 0, 0);
    check("ldrpc_pend_M", PCWrPendingF, 1);
    cyc(NOP, 4'h0, 0, 0);
    check("ldrpc_MemtoRegW", MemtoRegW, 1);
    check("ldrpc_PCSrcW", PCSrcW, 1);
    check("ldrpc_pend_W", PCWrPendingF, 0);
    // Flush beats a decodable ADD
    cyc(ADDR, 4'h0, 1, 0);
    cyc(NOP, 4'h0, 0, 0);
    check("flush_BranchTakenE", BranchTakenE, 0);
    cyc(NOP, 4'h0, 0, 0);
    check("flush_RegWriteM", RegWriteM, 0);
    cyc(NOP, 4'h0, 0, 0);
    check("flush_RegWriteW", RegWriteW, 0);
    // Async reset while STR is in Memory
    cyc(ADDS, 4'h0, 0, 0);
    cyc(STR, 4'b0100, 0, 0);
    cyc(NOP, 4'h0, 0, 0);
    cyc(NOP, 4'h0, 0, 0);
    check("str_MemWriteM_pre", MemWriteM, 1);
    check("adds_RegWriteW_pre", RegWriteW, 1);
    reset = 1'b1;
    model_clear();
    #1;
    check("rst_MemWriteM_now", MemWriteM, 0);
    check("rst_RegWriteW_now", RegWriteW, 0);
    compare_all();
    cyc(NOP, 4'h0, 0, 1);
    cyc(BEQ, 4'h0, 0, 0);
    cyc(NOP, 4'h0, 0, 0);
    check("rst_flags_cleared", BranchTakenE, 0);
    cyc(NOP, 4'h0, 0, 0);
    check("rst_no_write_M", MemWriteM, 0);
    cyc(BL, 4'h0, 0, 0);
    cyc(NOP, 4'h0, 0, 0);
    check("bl_taken", BranchTakenE, 1);
    cyc(NOP, 4'h0, 0, 0);
    cyc(NOP, 4'h0, 0, 0);
`ifdef ARM_BL_EN
    check("bl_BrLW", BrLW, 1);
`else
    check("bl_BrLW_off", BrLW, 0);
`endif
    check("bl_RegWriteW", RegWriteW, 0);

    for (int i = 0; i < 4000; i++)
      cyc(rand_instr(), 4'($urandom_range(0, 15)), $urandom_range(0, 6) == 0,
          $urandom_range(0, 199) == 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/arm_pipeline_controller.md
# arm_pipeline_controller

Control unit for the five-stage pipelined ARM core (Fetch, Decode, Execute, Memory, Writeback). It does four things:
- Decodes the instruction in Decode using the team's `decoder` block.
- Carries the resulting control word through Execute, Memory and Writeback pipeline registers.
- Holds the NZCV condition flags and evaluates each instruction's condition in Execute.
- Produces the branch-taken, PC-write-pending and write-enable signals that the datapath and hazard unit consume.

## Interface
Parameters:
- none

Ports:
- clk  in  1  single core clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all pipeline control registers and flags
- InstrD  in  20  Decode-stage instruction bits [31:12]: Cond[31:28], Op[27:26], Funct[25:20], Rd[15:12]
- ALUFlagsE  in  4  ALU result flags {N,Z,C,V} from Execute
- FlushE  in  1  from hazard unit; bubbles the Decode→Execute control register
- RegSrcD  out  2  register-source select for Decode
- ImmSrcD  out  2  immediate-extend select for Decode
- ALUSrcE  out  1  ALU B-operand select (1 = immediate)
- ALUControlE  out  3  ALU operation (000 ADD, 001 SUB, 010 AND, 011 ORR, 100 shift)
- BranchTakenE  out  1  conditional branch resolved taken in Execute
- MemtoRegE  out  1  Execute-stage load indicator for load-use hazard detection
- RegWriteM  out  1  gated register write in Memory, for forwarding
- MemWriteM  out  1  gated data-memory write enable
- RegWriteW  out  1  gated register-file write enable
- MemtoRegW  out  1  result select (1 = memory data)
- PCSrcW  out  1  write to PC in Writeback
- BrLW  out  1  link write (R14 ← PC+4) in Writeback
- PCWrPendingF  out  1  PC write in flight in Decode, Execute or Memory

## Operation
- Decode is combinational from InstrD through `decoder`. RegSrcD and ImmSrcD come straight from it.
- Decode→Execute register fields: PCS, RegW, MemW, Branch, BrL, MemtoReg, ALUSrc, ALUControl, FlagW, and Cond.
  - Reset or FlushE clears PCS, RegW, MemW, Branch, BrL and FlagW to 0. The other fields are don't-care.
  - FlushE has priority over the new Decode value.
- Flags register: 4 bits {N,Z,C,V}, reset to 0000.
- Condition check: CondExE = check(CondE, Flags) over all 15 ARM codes.
  - 1110 (AL) is always 1.
  - 1111 returns 0.
  - GE: N==V. GT: !Z & N==V. HI: C & !Z. LS: !C | Z.
- Gating in Execute, each term ANDed with CondExE:
  - RegWriteGE = RegWE
  - MemWriteGE = MemWE
  - PCSrcGE = PCSE
  - BrLGE = BrLE
  - BranchTakenE = BranchE
- Flag update at the clock edge:
  - If FlagWE[1] & CondExE, Flags[3:2] ← ALUFlagsE[3:2].
  - If FlagWE[0] & CondExE, Flags[1:0] ← ALUFlagsE[1:0].
- Execute→Memory register carries RegWriteG, MemWriteG, PCSrcG, BrLG and MemtoReg. Memory→Writeback carries RegWrite, PCSrc, BrL and MemtoReg. Neither register has a flush or stall.
- PCWrPendingF = PCSD | PCSE | PCSM. The Execute and Memory terms use the post-gating values.

## Timing
- Reset (asynchronous): every registered output is 0 and Flags are 0, immediately and independently of clk.
- Latency from Decode of an instruction:
  - Execute outputs valid 1 cycle later.
  - MemWriteM and RegWriteM valid 2 cycles later.
  - Writeback outputs valid 3 cycles later.
- A flag-setting instruction in Execute changes the condition seen by the next instruction's Execute cycle, 1 cycle later. There is no same-cycle bypass.
- FlushE and a decodable instruction in the same cycle: the bubble wins, and the Execute control bits are 0 next cycle.
- Reset asserted mid-operation drops all in-flight writes. No partial write is permitted after reset deasserts.

## Configuration
- ARM_BL_EN defined:
  - Op=10 with Funct[4]=1 decodes as BL.
  - BrL propagates and BrLW asserts in Writeback when the condition passes.
- ARM_BL_EN undefined:
  - BL decodes as plain B.
  - The BrL pipeline bits are removed and BrLW is tied to 0.

## Test plan
- ADDS R1 (AL, Funct=101001) with ALUFlagsE=0100 → ALUControlE=000 at +1 cycle; Flags=0100 after the edge; RegWriteW=1 at +3 cycles.
- With Z=1, BEQ (Cond=0000, Op=10) → BranchTakenE=1. With Z=0, BranchTakenE=0 and PCWrPendingF drops after Execute.
- STRNE (Cond=0001, Op=01, Funct[0]=0) with Z=1 → MemWriteM=0. With Z=0, MemWriteM=1 exactly 2 cycles after Decode.
- LDR to R15 → PCWrPendingF=1 for 3 consecutive cycles; MemtoRegW=1 and PCSrcW=1 at +3 cycles.
- FlushE=1 alongside a DP-register ADD in Decode → RegWriteM and RegWriteW remain 0 for that slot.
- Reset pulse while an STR is in Memory → MemWriteM=0 immediately, Flags=0000, no writes after release. Additionally, with ARM_BL_EN, BL → BrLW=1 at +3 cycles.
